dsp_mac_seq: RTL and testbench



---
 rtl/dsp_seq_pkg.sv | 17 +
 rtl/dsp_mac_seq_if.sv | 23 ++
 rtl/dsp_seq_delay.sv | 36 +++
 rtl/dsp_mac_seq.sv | 142 ++++++++++++++
 tb/tb_dsp_mac_seq.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared constants and FSM state type for the DSP-slice MAC sequencer.
package dsp_seq_pkg;

    localparam int WORD_W = 17;

    // OPMODE encodings: P = M + C for a live word, P = 0 for a bubble
    localparam logic [6:0] OPMODE_MC   = 7'b0110101;
    localparam logic [6:0] OPMODE_ZERO = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH
    } seq_state_t;

endpackage

// File: rtl/dsp_mac_seq_if.sv
// Word stream interface of the MAC sequencer: operand input handshake and result output strobe.
interface dsp_mac_seq_if;
    import dsp_seq_pkg::*;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [WORD_W-1:0] a_i;
    logic [WORD_W-1:0] t_i;
    logic              out_valid_o;
    logic [WORD_W-1:0] out_word_o;
    logic              out_last_o;

    modport master (
        output in_valid_i, a_i, t_i,
        input  in_ready_o, out_valid_o, out_word_o, out_last_o
    );

    modport slave (
        input  in_valid_i, a_i, t_i,
        output in_ready_o, out_valid_o, out_word_o, out_last_o
    );

endinterface

// File: rtl/dsp_seq_delay.sv
// Parameterised shift register used to align control with the DSP slice pipeline; depth 0 is a wire.
module dsp_seq_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Clearing on reset drops any in-flight tokens so nothing stale reaches the output
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_seq.sv
// Word-serial R = A*b + T sequencer that drives an external DSP slice and propagates the carry between words.
module dsp_mac_seq
    import dsp_seq_pkg::*;
#(
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int CREG  = 1,
    parameter int S     = 4
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic [WORD_W-1:0]   b_i,
    dsp_mac_seq_if.slave        io,
    output logic                busy_o,
    output logic [6:0]          dsp_OPMODE_o,
    output logic [WORD_W-1:0]   dsp_A_o,
    output logic [WORD_W-1:0]   dsp_B_o,
    output logic [2*WORD_W-1:0] dsp_C_o,
    output logic                dsp_CREG_en_o,
    input  logic [2*WORD_W-1:0] dsp_P_i
);

    localparam int DSP_REG_LEVEL = 1 + ABREG + MREG;
    localparam int C_DLY         = ABREG + MREG - CREG;
    localparam int OP_DLY        = ABREG + MREG - 1;
    localparam int CNT_W         = $clog2(S + 1);

    seq_state_t          state;
    logic [WORD_W-1:0]   b_q;
    logic [CNT_W-1:0]    in_cnt;
    logic [CNT_W-1:0]    out_cnt;
    logic [WORD_W-1:0]   carry;
    logic                out_valid_q;
    logic [WORD_W-1:0]   out_word_q;
    logic                out_last_q;
    logic                busy_q;

    logic                accept;
    logic                c_vld;
    logic [WORD_W-1:0]   c_t;
    logic                op_vld;
    logic                tok;
    logic [2*WORD_W-1:0] sum;

    assign accept = io.in_valid_i && (state == RUN);

    dsp_seq_delay #(.DEPTH(C_DLY), .WIDTH(WORD_W + 1)) u_c_dly (
        .clk  (clock_i),
        .rst_n(reset_n_i),
        .din  ({accept, io.t_i}),
        .dout ({c_vld, c_t})
    );

    dsp_seq_delay #(.DEPTH(OP_DLY), .WIDTH(1)) u_op_dly (
        .clk  (clock_i),
        .rst_n(reset_n_i),
        .din  (accept),
        .dout (op_vld)
    );

    // Token emerges exactly when dsp_P_i holds a_j*b + t_j for the matching word
    dsp_seq_delay #(.DEPTH(DSP_REG_LEVEL), .WIDTH(1)) u_tok_dly (
        .clk  (clock_i),
        .rst_n(reset_n_i),
        .din  (accept),
        .dout (tok)
    );

    assign dsp_A_o       = accept ? io.a_i : '0;
    assign dsp_B_o       = accept ? b_q : '0;
    assign dsp_CREG_en_o = c_vld;
    assign dsp_C_o       = c_vld ? {{WORD_W{1'b0}}, c_t} : '0;
    assign dsp_OPMODE_o  = op_vld ? OPMODE_MC : OPMODE_ZERO;

    assign sum = dsp_P_i + {{WORD_W{1'b0}}, carry};

    // Sequencer FSM with the carry chain and registered result stream
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            b_q         <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            carry       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (tok) begin
                out_valid_q <= 1'b1;
                out_word_q  <= sum[WORD_W-1:0];
                carry       <= sum[2*WORD_W-1:WORD_W];
                out_cnt     <= out_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start_i) begin
                        b_q     <= b_i;
                        carry   <= '0;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        in_cnt <= in_cnt + CNT_W'(1);
                        if (in_cnt == CNT_W'(S - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (tok && (out_cnt == CNT_W'(S - 1))) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The top word is whatever carry remains after the last product word
                    out_valid_q <= 1'b1;
                    out_word_q  <= carry;
                    out_last_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready_o  = (state == RUN);
    assign io.out_valid_o = out_valid_q;
    assign io.out_word_o  = out_word_q;
    assign io.out_last_o  = out_last_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Testbench for dsp_mac_seq: DSP slice model, table-driven runs with a scoreboard, and corner-case sequences.
module tb_dsp_mac_seq;
    import dsp_seq_pkg::*;

    localparam int S = 4;

    typedef struct {
        logic [16:0] b;
        logic [16:0] a [S];
        logic [16:0] t [S];
        int          gap;
        bit          glitch;
        logic [16:0] exp [S+1];
    } test_vec_t;

    typedef struct {
        logic [16:0] word;
        logic        last;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb [$];
    bit   busy_check_pending = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance under the main configuration (S=4)
    logic        start0, cen0, busy0;
    logic [16:0] b0, dA0, dB0;
    logic [33:0] dC0, p0;
    logic [6:0]  op0;
    dsp_mac_seq_if io0 ();

    dsp_mac_seq #(.ABREG(1), .MREG(1), .CREG(1), .S(S)) dut0 (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start0), .b_i(b0), .io(io0),
        .busy_o(busy0), .dsp_OPMODE_o(op0), .dsp_A_o(dA0), .dsp_B_o(dB0),
        .dsp_C_o(dC0), .dsp_CREG_en_o(cen0), .dsp_P_i(p0)
    );

    // Single-word build
    logic        start1, cen1, busy1;
    logic [16:0] b1, dA1, dB1;
    logic [33:0] dC1, p1;
    logic [6:0]  op1;
    dsp_mac_seq_if io1 ();

    dsp_mac_seq #(.ABREG(1), .MREG(1), .CREG(1), .S(1)) dut1 (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start1), .b_i(b1), .io(io1),
        .busy_o(busy1), .dsp_OPMODE_o(op1), .dsp_A_o(dA1), .dsp_B_o(dB1),
        .dsp_C_o(dC1), .dsp_CREG_en_o(cen1), .dsp_P_i(p1)
    );

    // DSP slice models: A/B reg, M reg, C reg with enable, OPMODE reg, P reg
    logic [16:0] mA0, mB0, mA1, mB1;
    logic [33:0] mM0, mC0, mM1, mC1;
    logic [6:0]  mOp0, mOp1;

    always @(posedge clk) begin
        mA0  <= dA0;
        mB0  <= dB0;
        mM0  <= {17'd0, mA0} * {17'd0, mB0};
        mOp0 <= op0;
        if (cen0) mC0 <= dC0;
        p0   <= (mOp0 == 7'b0110101) ? (mM0 + mC0) : 34'd0;
        mA1  <= dA1;
        mB1  <= dB1;
        mM1  <= {17'd0, mA1} * {17'd0, mB1};
        mOp1 <= op1;
        if (cen1) mC1 <= dC1;
        p1   <= (mOp1 == 7'b0110101) ? (mM1 + mC1) : 34'd0;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic test_vec_t withExpected(input test_vec_t v);
        logic [84:0] aw, tw, rw;
        aw = '0;
        tw = '0;
        for (int j = 0; j < S; j++) begin
            aw = aw | (85'(v.a[j]) << (17 * j));
            tw = tw | (85'(v.t[j]) << (17 * j));
        end
        rw = aw * 85'(v.b) + tw;
        for (int j = 0; j <= S; j++) v.exp[j] = rw[17*j +: 17];
        return v;
    endfunction

    // Result monitor: pops the scoreboard on every output strobe of the S=4 instance
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (busy_check_pending) begin
                checkOutput("busy_fall_after_last", 64'(busy0), 64'd0);
                busy_check_pending = 1'b0;
            end
            if (io0.out_valid_o) begin
                if (sb.size() == 0) begin
                    checkOutput("stray_out_valid", 64'(io0.out_valid_o), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_word", 64'(io0.out_word_o), 64'(e.word));
                    checkOutput("out_last", 64'(io0.out_last_o), 64'(e.last));
                    checkOutput("out_latency_cycle", 64'(cyc), 64'(e.due));
                    if (e.last) begin
                        checkOutput("busy_at_last", 64'(busy0), 64'd1);
                        busy_check_pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input test_vec_t v);
        int n;
        int last_acc;
        exp_t e;
        bit ok;
        ok = 1'b1;
        last_acc = 0;
        @(posedge clk); #1;
        start0 = 1'b1;
        b0 = v.b;
        @(posedge clk); #1;
        start0 = 1'b0;
        b0 = 17'($urandom);
        for (int j = 0; j < S && ok; j++) begin
            repeat (v.gap) begin
                io0.in_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            io0.in_valid_i = 1'b1;
            io0.a_i = v.a[j];
            io0.t_i = v.t[j];
            if (v.glitch && j == 1) begin
                start0 = 1'b1;
                b0 = 17'd7;
            end
            @(negedge clk);
            n = 0;
            while (!io0.in_ready_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!io0.in_ready_o) begin
                checkOutput("in_ready_timeout", 64'd0, 64'd1);
                ok = 1'b0;
            end else begin
                e.word = v.exp[j];
                e.last = 1'b0;
                e.due = cyc + 4;
                sb.push_back(e);
                last_acc = cyc;
            end
            @(posedge clk); #1;
            start0 = 1'b0;
        end
        io0.in_valid_i = 1'b0;
        if (ok) begin
            e.word = v.exp[S];
            e.last = 1'b1;
            e.due = last_acc + 5;
            sb.push_back(e);
        end
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    test_vec_t vec [5];
    test_vec_t rv;

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int n;
        int acc;
        start0 = 1'b0; b0 = '0;
        start1 = 1'b0; b1 = '0;
        io0.in_valid_i = 1'b1; io0.a_i = 17'h1234; io0.t_i = 17'h0abc;
        io1.in_valid_i = 1'b0; io1.a_i = '0; io1.t_i = '0;

        vec[0].b = 17'd3; vec[0].gap = 0; vec[0].glitch = 1'b0;
        vec[0].a = '{17'd5, 17'd0, 17'd0, 17'd0};
        vec[0].t = '{17'd1, 17'd0, 17'd0, 17'd0};
        vec[0].exp = '{17'd16, 17'd0, 17'd0, 17'd0, 17'd0};

        vec[1].b = 17'h1FFFF; vec[1].gap = 0; vec[1].glitch = 1'b0;
        vec[1].a = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        vec[1].t = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        vec[1].exp = '{17'h00000, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};

        vec[2] = vec[1];
        vec[2].gap = 1;

        vec[3] = vec[0];
        vec[3].glitch = 1'b1;

        vec[4].b = 17'd2; vec[4].gap = 0; vec[4].glitch = 1'b0;
        vec[4].a = '{17'h10000, 17'h10000, 17'd0, 17'd0};
        vec[4].t = '{17'h1FFFF, 17'd0, 17'd0, 17'd0};
        vec[4].exp = '{17'h1FFFF, 17'd1, 17'd1, 17'd0, 17'd0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(io0.out_valid_o), 64'd0);
        checkOutput("rst_out_word", 64'(io0.out_word_o), 64'd0);
        checkOutput("rst_out_last", 64'(io0.out_last_o), 64'd0);
        checkOutput("rst_busy", 64'(busy0), 64'd0);
        checkOutput("rst_in_ready", 64'(io0.in_ready_o), 64'd0);
        checkOutput("rst_opmode", 64'(op0), 64'd0);
        checkOutput("rst_dsp_a", 64'(dA0), 64'd0);
        checkOutput("rst_dsp_b", 64'(dB0), 64'd0);
        checkOutput("rst_dsp_c", 64'(dC0), 64'd0);
        checkOutput("rst_creg_en", 64'(cen0), 64'd0);
        io0.in_valid_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) applyStimulus(vec[i]);

        for (int r = 0; r < 3; r++) begin
            rv.b = 17'($urandom);
            rv.gap = $urandom_range(0, 2);
            rv.glitch = 1'b0;
            for (int j = 0; j < S; j++) begin
                rv.a[j] = 17'($urandom);
                rv.t[j] = 17'($urandom);
            end
            applyStimulus(withExpected(rv));
        end

        // Reset after two accepted words: in-flight results must vanish
        start0 = 1'b1; b0 = 17'd3;
        @(posedge clk); #1;
        start0 = 1'b0;
        io0.in_valid_i = 1'b1; io0.a_i = 17'd9; io0.t_i = 17'd4;
        @(posedge clk); #1;
        io0.a_i = 17'd11;
        @(posedge clk); #1;
        io0.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy0), 64'd0);
        checkOutput("midrst_opmode", 64'(op0), 64'd0);
        checkOutput("midrst_creg_en", 64'(cen0), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("no_stray_after_reset", 64'(io0.out_valid_o), 64'd0);
        end
        applyStimulus(vec[0]);

        // Single-word build emits exactly two words
        @(posedge clk); #1;
        start1 = 1'b1; b1 = 17'h1FFFF;
        @(posedge clk); #1;
        start1 = 1'b0;
        io1.in_valid_i = 1'b1; io1.a_i = 17'h1FFFF; io1.t_i = 17'h1FFFF;
        @(negedge clk);
        checkOutput("s1_in_ready", 64'(io1.in_ready_o), 64'd1);
        acc = cyc;
        @(posedge clk); #1;
        io1.in_valid_i = 1'b0;
        n = 0;
        while (!io1.out_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("s1_w0_cycle", 64'(cyc), 64'(acc + 4));
        checkOutput("s1_w0_word", 64'(io1.out_word_o), 64'h00000);
        checkOutput("s1_w0_last", 64'(io1.out_last_o), 64'd0);
        @(negedge clk);
        checkOutput("s1_w1_valid", 64'(io1.out_valid_o), 64'd1);
        checkOutput("s1_w1_word", 64'(io1.out_word_o), 64'h1FFFF);
        checkOutput("s1_w1_last", 64'(io1.out_last_o), 64'd1);
        @(negedge clk);
        checkOutput("s1_no_third_word", 64'(io1.out_valid_o), 64'd0);
        checkOutput("s1_busy_fall", 64'(busy1), 64'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
